// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - instruction fetch sequencer with next-pc selection and retire counter
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  input  logic        branch,
  input  logic        cond_true,
  input  logic        jump,
  input  logic        retire,
  output logic [31:0] retired_cnt
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  // Low two bits are forced to zero so a misconfigured parameter cannot
  // produce an unaligned first fetch.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] jump_target;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] next_pc;

  assign link_addr   = pc_q + 32'd4;
  assign imem_req    = (state_q == S_FETCH);
  assign inst_valid  = (state_q == S_HOLD);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign inst        = inst_q;
  assign retired_cnt = cnt_q;

  assign jump_target   = {link_addr[31:28], inst_q[25:0], 2'b00};
  assign branch_offset = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
  assign branch_target = link_addr + branch_offset;

  // Jump outranks a taken branch; all candidates are word aligned by construction.
  always_comb begin
    next_pc = link_addr;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && cond_true) begin
      next_pc = branch_target;
    end
  end

  // Sequencer: boot one cycle, fetch until ready, hold until the core retires.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          inst_d  = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (retire) begin
          pc_d    = next_pc;
          cnt_d   = cnt_q + 32'd1;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // State registers; reset takes effect immediately, aborting any open request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC_ALIGNED;
      inst_q  <= 32'h0000_0000;
      cnt_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed self-checking bench for pc_fetch
module tb_pc_fetch;

  logic        clk;
  logic        rst_n;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        branch;
  logic        cond_true;
  logic        jump;
  logic        retire;
  logic [31:0] retired_cnt;

  logic        b_imem_req;
  logic [31:0] b_imem_addr;
  logic        b_imem_ready;
  logic [31:0] b_imem_rdata;
  logic [31:0] b_inst;
  logic        b_inst_valid;
  logic [31:0] b_pc;
  logic [31:0] b_link_addr;
  logic        b_branch;
  logic        b_cond_true;
  logic        b_jump;
  logic        b_retire;
  logic [31:0] b_retired_cnt;

  int checks;
  int errors;

  pc_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .pc          (pc),
    .link_addr   (link_addr),
    .branch      (branch),
    .cond_true   (cond_true),
    .jump        (jump),
    .retire      (retire),
    .retired_cnt (retired_cnt)
  );

  pc_fetch #(.RESET_PC(32'h8000_0010)) dut_hi (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (b_imem_req),
    .imem_addr   (b_imem_addr),
    .imem_ready  (b_imem_ready),
    .imem_rdata  (b_imem_rdata),
    .inst        (b_inst),
    .inst_valid  (b_inst_valid),
    .pc          (b_pc),
    .link_addr   (b_link_addr),
    .branch      (b_branch),
    .cond_true   (b_cond_true),
    .jump        (b_jump),
    .retire      (b_retire),
    .retired_cnt (b_retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    imem_ready   = 1'b1;
    imem_rdata   = 32'h0800_0040;
    branch       = 1'b0;
    cond_true    = 1'b0;
    jump         = 1'b0;
    retire       = 1'b0;
    b_imem_ready = 1'b1;
    b_imem_rdata = 32'h0C00_0040;
    b_branch     = 1'b1;
    b_cond_true  = 1'b0;
    b_jump       = 1'b1;
    b_retire     = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_req",   {31'd0, imem_req},   32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_pc",    pc,          32'h0);
    check("rst_inst",  inst,        32'h0);
    check("rst_cnt",   retired_cnt, 32'h0);
    check("rst_b_pc",  b_pc,        32'h8000_0010);

    // Release: BOOT, then FETCH at 0, then HOLD with zero-wait memory
    rst_n = 1'b1;
    check("boot_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("f1_req",   {31'd0, imem_req},   32'd1);
    check("f1_addr",  imem_addr,           32'h0);
    check("f1_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    check("h1_valid", {31'd0, inst_valid}, 32'd1);
    check("h1_req",   {31'd0, imem_req},   32'd0);
    check("h1_pc",    pc,                  32'h0);
    check("h1_link",  link_addr,           32'h4);
    check("h1_inst",  inst,                32'h0800_0040);
    check("b_pc",     b_pc,                32'h8000_0010);
    check("b_link",   b_link_addr,         32'h8000_0014);
    check("b_inst",   b_inst,              32'h0C00_0040);

    // ready while not requesting is ignored
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    check("hold_inst",  inst, 32'h0800_0040);
    check("hold_valid", {31'd0, inst_valid}, 32'd1);

    // Jump to 0x100; jal with branch also set on the high instance
    jump = 1'b1; retire = 1'b1; b_retire = 1'b1;
    tick();
    jump = 1'b0; retire = 1'b0; b_retire = 1'b0; b_imem_ready = 1'b0;
    imem_ready = 1'b0;
    check("j_addr",   imem_addr,     32'h0000_0100);
    check("j_req",    {31'd0, imem_req}, 32'd1);
    check("j_cnt",    retired_cnt,   32'd1);
    check("jal_addr", b_imem_addr,   32'h8000_0100);
    check("jal_cnt",  b_retired_cnt, 32'd1);

    // Three wait cycles with a stray retire that must be ignored
    retire = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("wait_req",  {31'd0, imem_req}, 32'd1);
      check("wait_addr", imem_addr,         32'h0000_0100);
      tick();
    end
    imem_ready = 1'b1;
    imem_rdata = 32'h1000_FFFE;
    check("wait_req3", {31'd0, imem_req}, 32'd1);
    tick();
    retire = 1'b0; imem_ready = 1'b0;
    check("w_valid", {31'd0, inst_valid}, 32'd1);
    check("w_inst",  inst,        32'h1000_FFFE);
    check("w_pc",    pc,          32'h0000_0100);
    check("w_cnt",   retired_cnt, 32'd1);

    // Taken branch, offset -2 words
    branch = 1'b1; cond_true = 1'b1; retire = 1'b1;
    tick();
    branch = 1'b0; cond_true = 1'b0; retire = 1'b0;
    check("bt_addr", imem_addr,   32'h0000_00FC);
    check("bt_cnt",  retired_cnt, 32'd2);
    imem_ready = 1'b1; imem_rdata = 32'h0800_0040;
    tick();
    imem_ready = 1'b0;

    // Back to 0x100 via jump
    jump = 1'b1; retire = 1'b1;
    tick();
    jump = 1'b0; retire = 1'b0;
    check("j2_addr", imem_addr, 32'h0000_0100);
    imem_ready = 1'b1; imem_rdata = 32'h1000_FFFE;
    tick();
    imem_ready = 1'b0;

    // Branch not taken
    branch = 1'b1; cond_true = 1'b0; retire = 1'b1;
    tick();
    branch = 1'b0; retire = 1'b0;
    check("bn_addr", imem_addr,   32'h0000_0104);
    check("bn_cnt",  retired_cnt, 32'd4);
    imem_ready = 1'b1; imem_rdata = 32'h0800_0000;
    tick();
    imem_ready = 1'b0;

    // Jump to 0, then branch backwards across zero
    jump = 1'b1; retire = 1'b1;
    tick();
    jump = 1'b0; retire = 1'b0;
    check("j0_addr", imem_addr, 32'h0);
    imem_ready = 1'b1; imem_rdata = 32'h1000_FFFE;
    tick();
    imem_ready = 1'b0;
    branch = 1'b1; cond_true = 1'b1; retire = 1'b1;
    tick();
    branch = 1'b0; cond_true = 1'b0; retire = 1'b0;
    check("neg_addr", imem_addr,   32'hFFFF_FFFC);
    check("neg_cnt",  retired_cnt, 32'd6);
    imem_ready = 1'b1; imem_rdata = 32'h0000_0000;
    tick();
    imem_ready = 1'b0;
    check("wrap_link", link_addr, 32'h0);

    // Sequential retire at the top of memory wraps to 0
    retire = 1'b1;
    tick();
    retire = 1'b0;
    check("wrap_addr", imem_addr,   32'h0);
    check("wrap_cnt",  retired_cnt, 32'd7);

    // Reset mid-fetch with ready high: nothing latched
    imem_ready = 1'b1; imem_rdata = 32'hCAFE_0000;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_req",   {31'd0, imem_req},   32'd0);
    check("ar_valid", {31'd0, inst_valid}, 32'd0);
    check("ar_inst",  inst,        32'h0);
    check("ar_cnt",   retired_cnt, 32'h0);
    tick();
    check("ar_inst2", inst, 32'h0);
    rst_n = 1'b1;
    imem_ready = 1'b0;
    tick();
    check("ar_req2",  {31'd0, imem_req}, 32'd1);
    check("ar_addr",  imem_addr,         32'h0);
    check("ar_inst3", inst,              32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, the first fetch address after reset; bits [1:0] are always 00.
REQ-002 Port: clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: imem_req  out  1  instruction-memory read request.
REQ-005 Port: imem_addr  out  32  byte address of the request; equals pc.
REQ-006 Port: imem_ready  in  1  read data valid; sampled only while imem_req=1.
REQ-007 Port: imem_rdata  in  32  instruction word.
REQ-008 Port: inst  out  32  held instruction; feeds the opcode field [31:26] and rt field [20:16] to the decoder.
REQ-009 Port: inst_valid  out  1  inst and pc describe a fetched instruction awaiting retire.
REQ-010 Port: pc  out  32  address of the held instruction.
REQ-011 Port: link_addr  out  32  pc+4, the return address for jal.
REQ-012 Port: branch  in  1  decoder branch class.
REQ-013 Port: cond_true  in  1  branch condition result from the ALU/zcond logic.
REQ-014 Port: jump  in  1  decoder jump (j/jal).
REQ-015 Port: retire  in  1  core has completed the held instruction this cycle.
REQ-016 Port: retired_cnt  out  32  count of retired instructions.

Function
REQ-017 States: BOOT, FETCH, HOLD; BOOT is the reset state.
REQ-018 BOOT: imem_req=0 and inst_valid=0; the block unconditionally moves to FETCH on the next edge.
REQ-019 FETCH: imem_req=1, imem_addr=pc held stable; on an edge with imem_ready=1, the block latches inst<=imem_rdata and moves to HOLD; otherwise it stays in FETCH.
REQ-020 Zero-wait memory: imem_ready=1 in the first FETCH cycle is legal; HOLD then follows one cycle later, so minimum fetch latency is 1 cycle.
REQ-021 HOLD: imem_req=0, inst_valid=1; inst and pc stay stable until retire.
REQ-022 HOLD with retire=1: pc<=next_pc, retired_cnt<=retired_cnt+1, move to FETCH on the same edge.
REQ-023 next_pc priority: jump first -> {link_addr[31:28], inst[25:0], 2'b00}; then branch&cond_true -> link_addr + (sign-extended inst[15:0] << 2); otherwise -> link_addr.
REQ-024 jump and branch both asserted: the jump target wins.
REQ-025 All address arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
REQ-026 next_pc[1:0] is always 00 by construction.
REQ-027 retire asserted in BOOT or FETCH is ignored: no pc change, no count change.
REQ-028 imem_ready asserted while imem_req=0 is ignored.
REQ-029 branch, cond_true and jump are sampled only on the retire edge.
REQ-030 link_addr is combinational from pc.
REQ-031 retired_cnt wraps from 32'hFFFF_FFFF to 0.

Reset
REQ-032 rst_n low immediately forces state=BOOT, pc=RESET_PC, inst=0, retired_cnt=0, imem_req=0, inst_valid=0, independent of clk.
REQ-033 Reset asserted during FETCH aborts the request; no data is latched; after release, the block refetches from RESET_PC.
REQ-034 Deassertion of rst_n is synchronous to clk by the system; the first active edge after release leaves BOOT.

Verification
REQ-035 Reset release, imem_ready tied 1 -> edge1 FETCH addr 0; edge2 HOLD, inst_valid=1, pc=0, link_addr=4.
REQ-036 Three-cycle memory wait -> imem_req=1 and imem_addr constant for 3 cycles; HOLD entered after the edge where ready=1.
REQ-037 pc=0x100, inst=0x1000_FFFE (beq, offset -2), branch=1, cond_true=1, retire -> next fetch addr 0x0FC; with cond_true=0 -> 0x104.
REQ-038 pc=0x8000_0010, inst=0x0C00_0040 (jal), jump=1, branch=1, retire -> next fetch addr 0x8000_0100; link_addr before retire = 0x8000_0014.
REQ-039 pc=0xFFFF_FFFC, no branch/jump, retire -> next fetch addr 0x0000_0000; retired_cnt increments by 1.
REQ-040 rst_n pulsed low mid-FETCH with imem_ready=1 in that cycle -> inst stays 0, retired_cnt=0, and the next request is at RESET_PC.
